// File: rtl/axi_stream_strip_header.sv
// Removes a per-packet count of leading bytes from an AXI Stream packet and re-packs the payload.
// Define AXIS_STRIP_CNT_EN to add the pkt_cnt / drop_cnt statistics outputs.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [LEN_WD-1:0]       strip_len,
  output logic                    ready_strip,
  output logic                    err_short
`ifdef AXIS_STRIP_CNT_EN
  ,
  output logic [15:0]             pkt_cnt,
  output logic [15:0]             drop_cnt
`endif
);

  localparam logic [LEN_WD-1:0] BYTES = LEN_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, FIRST, MID, FLUSH} state_t;

  state_t                  state_q;
  logic [LEN_WD-1:0]       s_q;
  logic [LEN_WD-1:0]       k_q;
  logic [LEN_WD-1:0]       n_q;
  logic [DATA_WD-1:0]      carry_q;
  logic                    valid_out_q;
  logic [DATA_WD-1:0]      data_out_q;
  logic [DATA_BYTE_WD-1:0] keep_out_q;
  logic                    last_out_q;
  logic                    err_q;

  logic                    out_free;
  logic                    in_fire;
  logic [LEN_WD-1:0]       s_c;
  logic [LEN_WD-1:0]       k_c;
  logic [LEN_WD-1:0]       n_c;
  logic [DATA_WD-1:0]      shl_k;
  logic [DATA_WD-1:0]      top_k;

  logic                    emit_d;
  logic [DATA_WD-1:0]      beat_d;
  logic [DATA_BYTE_WD-1:0] bkeep_d;
  logic                    blast_d;
  logic                    drop_d;

  function automatic logic [DATA_BYTE_WD-1:0] keep_top(input int m);
    logic [DATA_BYTE_WD-1:0] kt;
    kt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < m) kt[DATA_BYTE_WD-1-i] = 1'b1;
    return kt;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] kp);
    logic [DATA_WD-1:0] bm;
    bm = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      bm[8*i +: 8] = {8{kp[i]}};
    return bm;
  endfunction

  function automatic logic [LEN_WD-1:0] lead_ones(input logic [DATA_BYTE_WD-1:0] kp);
    logic [LEN_WD-1:0] cnt;
    logic              run;
    cnt = '0;
    run = 1'b1;
    for (int i = DATA_BYTE_WD - 1; i >= 0; i--) begin
      if (run && kp[i]) cnt = cnt + LEN_WD'(1);
      else              run = 1'b0;
    end
    return cnt;
  endfunction

  assign out_free    = ~valid_out_q | ready_out;
  assign ready_in    = ((state_q == FIRST) || (state_q == MID)) && out_free;
  assign ready_strip = (state_q == IDLE);
  assign in_fire     = valid_in & ready_in;

  assign s_c = (strip_len > BYTES) ? BYTES : strip_len;
  assign k_c = (s_c == BYTES) ? '0 : s_c;
  assign n_c = lead_ones(keep_in);

  // shl_k keeps the bytes past the strip point MSB-aligned; top_k is the head that completes a carried beat
  assign shl_k = data_in << {k_q, 3'b000};
  assign top_k = (k_q == '0) ? '0 : (data_in >> {BYTES - k_q, 3'b000});

  always_comb begin
    emit_d  = 1'b0;
    beat_d  = '0;
    bkeep_d = '0;
    blast_d = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      FIRST: begin
        if (in_fire) begin
          if (last_in) begin
            if (n_c <= s_q) begin
              drop_d = 1'b1;
            end else begin
              emit_d  = 1'b1;
              beat_d  = shl_k;
              bkeep_d = keep_top(int'(n_c) - int'(s_q));
              blast_d = 1'b1;
            end
          end else if (s_q == '0) begin
            emit_d  = 1'b1;
            beat_d  = data_in;
            bkeep_d = keep_in;
          end
        end
      end
      MID: begin
        if (in_fire) begin
          emit_d = 1'b1;
          if (k_q == '0) begin
            beat_d  = data_in;
            bkeep_d = keep_in;
            blast_d = last_in;
          end else begin
            beat_d = carry_q | top_k;
            if (last_in && (n_c <= k_q)) begin
              bkeep_d = keep_top(DATA_BYTE_WD - int'(k_q) + int'(n_c));
              blast_d = 1'b1;
            end else begin
              bkeep_d = '1;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          emit_d  = 1'b1;
          beat_d  = carry_q;
          bkeep_d = keep_top(int'(n_q) - int'(k_q));
          blast_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      carry_q     <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= drop_d;
      if (emit_d) begin
        valid_out_q <= 1'b1;
        data_out_q  <= beat_d & byte_mask(bkeep_d);
        keep_out_q  <= bkeep_d;
        last_out_q  <= blast_d;
      end else if (ready_out) begin
        valid_out_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (valid_strip) begin
            s_q     <= s_c;
            k_q     <= k_c;
            state_q <= FIRST;
          end
        end
        FIRST: begin
          if (in_fire) begin
            carry_q <= shl_k;
            state_q <= last_in ? IDLE : MID;
          end
        end
        MID: begin
          if (in_fire) begin
            carry_q <= shl_k;
            n_q     <= n_c;
            if (last_in)
              state_q <= ((k_q != '0) && (n_c > k_q)) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          if (out_free) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXIS_STRIP_CNT_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (valid_out_q && ready_out && last_out_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (err_q) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;
  assign err_short = err_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Testbench for axi_stream_strip_header: directed and random packets checked against a byte-queue model.
module tb_axi_stream_strip_header;
  localparam int DW = 32;
  localparam int B  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [B-1:0]  keep_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [B-1:0]  keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_strip;
  logic [LW-1:0] strip_len;
  logic          ready_strip;
  logic          err_short;
`ifdef AXIS_STRIP_CNT_EN
  logic [15:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
`endif

  axi_stream_strip_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_strip(valid_strip), .strip_len(strip_len), .ready_strip(ready_strip),
    .err_short(err_short)
`ifdef AXIS_STRIP_CNT_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int rdy_mode = 0;
  int pidx = 0;
  int exp_pkts = 0;
  int exp_drops = 0;

  logic [7:0]    pkt[$];
  logic [DW-1:0] got_d[$];
  logic [B-1:0]  got_k[$];
  logic          got_l[$];

  logic          prev_stall = 1'b0;
  logic          prev_err = 1'b0;
  logic [DW-1:0] held_d = '0;
  logic [B-1:0]  held_k = '0;
  logic          held_l = 1'b0;
  logic [3:0]    pat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gd(input int i);
    if (i < got_d.size()) return got_d[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gk(input int i);
    if (i < got_k.size()) return 32'(got_k[i]);
    return 32'hDEAD_BEEF;
  endfunction

  // Output monitor: records accepted beats and checks stall stability and err_short width
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_err   <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(valid_out), 32'd1);
        check("hold_data", data_out, held_d);
        check("hold_keep", 32'(keep_out), 32'(held_k));
        check("hold_last", 32'(last_out), 32'(held_l));
      end
      if (valid_out && ready_out) begin
        got_d.push_back(data_out);
        got_k.push_back(keep_out);
        got_l.push_back(last_out);
      end
      if (err_short) begin
        err_pulses++;
        check("err_width", 32'(prev_err), 32'd0);
      end
      prev_stall <= valid_out && !ready_out;
      held_d     <= data_out;
      held_k     <= keep_out;
      held_l     <= last_out;
      prev_err   <= err_short;
    end
  end

  // Downstream ready generator: 0 always ready, 1 random, 2 repeating 1,0,0,1
  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ready_out = 1'b1;
        1: ready_out = 1'($urandom_range(0, 1));
        default: begin
          ready_out = pat[3 - (pidx % 4)];
          pidx++;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_strip(input int len);
    logic hs;
    hs = 1'b0;
    valid_strip = 1'b1;
    strip_len = LW'(len);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      hs = ready_strip;
      tick();
      if (hs) break;
    end
    if (!hs) check("strip_hs_timeout", 32'(hs), 32'd1);
    valid_strip = 1'b0;
  endtask

  task automatic send_beats(input int max_beats);
    int nb;
    logic hs;
    nb = (pkt.size() + B - 1) / B;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        tick();
      end
      data_in = '0;
      keep_in = '0;
      for (int j = 0; j < B; j++) begin
        if (b * B + j < pkt.size()) begin
          data_in[DW-1-8*j -: 8] = pkt[b * B + j];
          keep_in[B-1-j] = 1'b1;
        end else begin
          data_in[DW-1-8*j -: 8] = 8'($urandom);
        end
      end
      last_in = (b == nb - 1);
      valid_in = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        hs = ready_in;
        tick();
        if (hs) break;
      end
      if (!hs) check("beat_hs_timeout", 32'(hs), 32'd1);
    end
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  // Reference: strip min(len,B) bytes from the packet byte list, then re-chunk into full beats
  task automatic run_pkt(input int len, input string tag);
    int s_eff, r, nb, e0;
    logic [DW-1:0] ed[$];
    logic [B-1:0]  ek[$];
    logic          el[$];
    logic [DW-1:0] d;
    logic [B-1:0]  k;
    s_eff = (len > B) ? B : len;
    r = pkt.size() - s_eff;
    nb = (r > 0) ? (r + B - 1) / B : 0;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < B; j++) begin
        if (s_eff + b * B + j < pkt.size()) begin
          d[DW-1-8*j -: 8] = pkt[s_eff + b * B + j];
          k[B-1-j] = 1'b1;
        end
      end
      ed.push_back(d);
      ek.push_back(k);
      el.push_back(b == nb - 1);
    end
    got_d.delete();
    got_k.delete();
    got_l.delete();
    e0 = err_pulses;
    send_strip(len);
    send_beats(1000);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if ((nb == 0) ? (err_pulses > e0) : (got_d.size() >= nb)) break;
    end
    repeat (3) @(negedge clk);
    check({tag, "_nbeats"}, 32'(got_d.size()), 32'(nb));
    check({tag, "_err"}, 32'(err_pulses - e0), (nb == 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < nb && i < got_d.size(); i++) begin
      check({tag, "_data"}, got_d[i], ed[i]);
      check({tag, "_keep"}, 32'(got_k[i]), 32'(ek[i]));
      check({tag, "_last"}, 32'(got_l[i]), 32'(el[i]));
    end
    if (nb == 0) exp_drops++;
    else         exp_pkts++;
    tick();
  endtask

  task automatic rand_pkt(input int nbytes);
    pkt.delete();
    for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    keep_in = '0;
    last_in = 1'b0;
    valid_strip = 1'b0;
    strip_len = '0;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_keep_out", 32'(keep_out), 32'd0);
    check("rst_last_out", 32'(last_out), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd0);
    check("rst_ready_strip", 32'(ready_strip), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_pkt(0, "s0");
    check("s0_b0", gd(0), 32'hAABBCCDD);
    check("s0_b1", gd(1), 32'h11220000);
    check("s0_k1", gk(1), 32'h0000000C);

    run_pkt(1, "s1");
    check("s1_b0", gd(0), 32'hBBCCDD11);
    check("s1_b1", gd(1), 32'h22000000);
    check("s1_k1", gk(1), 32'h00000008);

    pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33};
    run_pkt(3, "s3");
    check("s3_b0", gd(0), 32'hDD112233);
    check("s3_k0", gk(0), 32'h0000000F);

    pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    run_pkt(4, "s4");
    check("s4_b0", gd(0), 32'h11223344);
    run_pkt(7, "s7_clamp");

    pkt = {8'hAA, 8'hBB};
    run_pkt(2, "short");
    check("short_ready_strip", 32'(ready_strip), 32'd1);
    pkt = {8'h01, 8'h02, 8'h03, 8'h04};
    run_pkt(4, "full_drop");

    rdy_mode = 2;
    pidx = 0;
    rand_pkt(16);
    run_pkt(1, "stall");

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      rand_pkt($urandom_range(1, 14));
      run_pkt($urandom_range(0, 7), "rnd");
    end

`ifdef AXIS_STRIP_CNT_EN
    check("pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_pkts)));
    check("drop_cnt", 32'(drop_cnt), 32'(16'(exp_drops)));
`endif

    // Abort a packet with reset after two of its four beats
    rdy_mode = 2;
    pidx = 0;
    rand_pkt(16);
    send_strip(1);
    send_beats(2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_out", 32'(valid_out), 32'd0);
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_keep_out", 32'(keep_out), 32'd0);
    check("mid_rst_last_out", 32'(last_out), 32'd0);
    check("mid_rst_err_short", 32'(err_short), 32'd0);
    check("mid_rst_ready_strip", 32'(ready_strip), 32'd1);
    check("mid_rst_ready_in", 32'(ready_in), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_pkts = 0;
    exp_drops = 0;
    got_d.delete();
    got_k.delete();
    got_l.delete();
    repeat (6) @(negedge clk);
    check("post_rst_no_output", 32'(got_d.size()), 32'd0);
    check("post_rst_valid_out", 32'(valid_out), 32'd0);
    tick();

    rdy_mode = 1;
    rand_pkt(9);
    run_pkt(2, "recover");

`ifdef AXIS_STRIP_CNT_EN
    check("pkt_cnt_after_rst", 32'(pkt_cnt), 32'(16'(exp_pkts)));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
